decode_stage: RTL

- Registered, parametrised RISC-V decode stage between the fetch and issue/execute stages.
- Accepts {pc, instr} through a valid/ready handshake and extracts register indices, opcode, func3, func7, the sign/zero-extended immediate, CSR id and zimm.
- Flags illegal encodings and buffers decoded entries in a small in-order queue so fetch and execute can stall independently.
- Supports RV32 or RV64, with optional M-extension acceptance and a flush input.

---
 rtl/decode_pkg.sv | 106 ++++++++++
 rtl/decode_fields.sv | 17 +
 rtl/decode_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared opcode constants, immediate-select enum and decoded-entry struct for
// the decode stage. Decoding is done at 64 bits and truncated to XLEN by users.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I, IMM_ISH, IMM_ISHW, IMM_U, IMM_J, IMM_B, IMM_S, IMM_NONE
  } imm_sel_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        arith;
    logic [63:0] imm;
    logic [63:0] zimm;
    logic [11:0] csr_id;
    logic        illegal;
  } decoded_t;

  function automatic imm_sel_e imm_sel_of(input logic [31:0] instr);
    logic is_shift;
    is_shift = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);
    case (instr[6:0])
      OPC_LOAD, OPC_JALR: imm_sel_of = IMM_I;
      OPC_OP_IMM:         imm_sel_of = is_shift ? IMM_ISH : IMM_I;
      OPC_OP_IMM_32:      imm_sel_of = is_shift ? IMM_ISHW : IMM_I;
      OPC_LUI, OPC_AUIPC: imm_sel_of = IMM_U;
      OPC_JAL:            imm_sel_of = IMM_J;
      OPC_BRANCH:         imm_sel_of = IMM_B;
      OPC_STORE:          imm_sel_of = IMM_S;
      default:            imm_sel_of = IMM_NONE;
    endcase
  endfunction

  // U immediate is kept unshifted; downstream adds the <<12 where needed.
  function automatic logic [63:0] imm_of(input imm_sel_e sel, input logic [31:0] instr,
                                         input int xlen);
    case (sel)
      IMM_I:    imm_of = {{52{instr[31]}}, instr[31:20]};
      IMM_ISH:  imm_of = (xlen == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      IMM_ISHW: imm_of = {59'b0, instr[24:20]};
      IMM_U:    imm_of = {{44{instr[31]}}, instr[31:12]};
      IMM_J:    imm_of = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_B:    imm_of = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_S:    imm_of = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      default:  imm_of = 64'b0;
    endcase
  endfunction

  function automatic logic illegal_of(input logic [31:0] instr, input int xlen,
                                      input logic has_m);
    logic [6:0] opc;
    logic       bad;
    opc = instr[6:0];
    bad = (instr[1:0] != 2'b11);
    case (opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_OP_32, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: ;
      default: bad = 1'b1;
    endcase
    if (xlen == 32 && (opc == OPC_OP_IMM_32 || opc == OPC_OP_32)) bad = 1'b1;
    if (xlen == 32 && opc == OPC_OP_IMM && instr[13:12] == 2'b01 && instr[25]) bad = 1'b1;
    if ((opc == OPC_OP || opc == OPC_OP_32) &&
        !(instr[31:25] == 7'b0000000 || instr[31:25] == 7'b0100000 ||
          (has_m && instr[31:25] == 7'b0000001)))
      bad = 1'b1;
    illegal_of = bad;
  endfunction

  function automatic decoded_t decode(input logic [31:0] instr, input logic [63:0] pc,
                                      input int xlen, input logic has_m);
    decoded_t d;
    d.pc      = pc;
    d.rs1     = instr[19:15];
    d.rs2     = instr[24:20];
    d.rd      = instr[11:7];
    d.opcode  = instr[6:0];
    d.func3   = instr[14:12];
    d.func7   = instr[31:25];
    d.arith   = instr[30];
    d.imm     = imm_of(imm_sel_of(instr), instr, xlen);
    d.zimm    = {59'b0, instr[19:15]};
    d.csr_id  = instr[31:20];
    d.illegal = illegal_of(instr, xlen, has_m);
    decode    = d;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Purely combinational field extraction for one instruction word.
module decode_fields
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter bit HAS_M = 1'b1
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output decoded_t        dec_o
);

  always_comb begin
    dec_o = decode(instr_i, 64'(pc_i), XLEN, HAS_M);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes {pc, instr} on push and holds entries in a
// small in-order queue; outputs come only from storage.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter bit HAS_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic            out_arith,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_zimm,
  output logic [11:0]     out_csr_id,
  output logic            out_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  decoded_t        dec;
  decoded_t        mem_q [DEPTH];
  decoded_t        head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  decode_fields #(.XLEN(XLEN), .HAS_M(HAS_M)) u_fields (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .dec_o   (dec)
  );

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_pc      = head.pc[XLEN-1:0];
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_opcode  = head.opcode;
  assign out_func3   = head.func3;
  assign out_func7   = head.func7;
  assign out_arith   = head.arith;
  assign out_imm     = head.imm[XLEN-1:0];
  assign out_zimm    = head.zimm[XLEN-1:0];
  assign out_csr_id  = head.csr_id;
  assign out_illegal = head.illegal;

endmodule
